// File: rtl/fft_pkg.sv
// Shared constants and index helpers for the 16-point FFT datapath.
// The twiddle ROM, the butterfly stages and the bit-reversal buffer all
// size their address arithmetic from these definitions.
package fft_pkg;

  localparam int FFT_POINTS = 16;
  localparam int FFT_LOG2   = 4;

  // Index of one sample inside a frame.
  typedef logic [FFT_LOG2-1:0] fft_idx_t;

  // Highest index in a frame; the counters wrap after it.
  localparam fft_idx_t FFT_LAST_IDX = fft_idx_t'(FFT_POINTS - 1);

  // Reverse the FFT_LOG2 address bits: bit i of the result is bit
  // (FFT_LOG2-1-i) of the argument.
  function automatic fft_idx_t bitrev(input fft_idx_t k);
    fft_idx_t r;
    r = '0;
    for (int i = 0; i < FFT_LOG2; i++) begin
      r[i] = k[FFT_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reg_bank.sv
// One frame of sample storage: FFT_POINTS words of N bits with a single
// synchronous write port and a single asynchronous read port. Contents
// are not reset; the owner tracks which words hold valid data.
module fft_reg_bank
  import fft_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [FFT_LOG2-1:0] waddr,
  input  logic [N-1:0]        wdata,
  input  logic [FFT_LOG2-1:0] raddr,
  output logic [N-1:0]        rdata
);

  logic [N-1:0] mem [FFT_POINTS];

  // Write one word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is a plain mux on the stored words, no clock involved.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buf.sv
// Bit-reversal reorder buffer for the 16-point FFT.
// Samples arrive in natural order and are written into one of two register
// banks. Once a bank holds a whole frame it is marked full and drained in
// bit-reversed address order while the other bank fills, giving one sample
// per cycle sustained.
//
// Handshakes: on both sides a transfer happens in any cycle where valid and
// ready are both high at the rising clock edge. The input side (i_valid /
// o_ready) holds data until accepted; the output side (o_valid / i_ready)
// keeps o_data, o_index and o_last stable while o_valid is high and i_ready
// is low. o_ready and o_valid come from registered state only, so neither
// ready input has a combinational path to the opposite side.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  output logic [3:0]   o_index,
  output logic         o_last,
  input  logic         i_ready
);

  // Frame-level state: which banks hold a full frame, and the write and
  // read cursors (bank select plus position within the frame).
  logic [1:0] bank_full;
  logic [1:0] bank_full_nxt;
  logic       wr_bank;
  logic       rd_bank;
  fft_idx_t   wr_cnt;
  fft_idx_t   rd_cnt;

  // Transfer qualifiers.
  logic       wr_fire;
  logic       rd_fire;
  logic       wr_wrap;
  logic       rd_wrap;

  // Bank ports.
  logic       we0;
  logic       we1;
  fft_idx_t   raddr;
  logic [N-1:0] rdata0;
  logic [N-1:0] rdata1;

  // The writer may use its bank only while that bank is not holding a
  // frame; the reader may use its bank only while it is. A write and a read
  // in the same cycle therefore always hit different banks.
  assign o_ready = !bank_full[wr_bank];
  assign o_valid = bank_full[rd_bank];

  assign wr_fire = i_valid && o_ready;
  assign rd_fire = o_valid && i_ready;
  assign wr_wrap = wr_fire && (wr_cnt == FFT_LAST_IDX);
  assign rd_wrap = rd_fire && (rd_cnt == FFT_LAST_IDX);

  assign we0   = wr_fire && !wr_bank;
  assign we1   = wr_fire &&  wr_bank;
  assign raddr = bitrev(rd_cnt);

  fft_reg_bank #(.N(N)) u_bank0 (
    .clk   (i_clk),
    .we    (we0),
    .waddr (wr_cnt),
    .wdata (i_data),
    .raddr (raddr),
    .rdata (rdata0)
  );

  fft_reg_bank #(.N(N)) u_bank1 (
    .clk   (i_clk),
    .we    (we1),
    .waddr (wr_cnt),
    .wdata (i_data),
    .raddr (raddr),
    .rdata (rdata1)
  );

  // Output side is purely combinational from the read cursor and banks.
  assign o_data  = rd_bank ? rdata1 : rdata0;
  assign o_index = rd_cnt;
  assign o_last  = o_valid && (rd_cnt == FFT_LAST_IDX);

  // Next full flags: completing a write frame sets its bank, completing a
  // read frame clears its bank. Both can happen in one cycle on different
  // banks.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_wrap) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_wrap) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  // Register the flags and advance the cursors; reset drops any partial
  // frames on both sides.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + fft_idx_t'(1);
      end
      if (wr_wrap) begin
        wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + fft_idx_t'(1);
      end
      if (rd_wrap) begin
        rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed and random checks for the bit-reversal reorder buffer.
module tb_fft_bitrev_buf;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic [3:0]  o_index;
  logic        o_last;
  logic        i_ready;

  int n_checks;
  int n_fail;

  // Hand-written bit-reversed order of 0..15.
  int brev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // Outputs sampled just after the inputs of a cycle are applied.
  logic        s_ready;
  logic        s_valid;
  logic [15:0] s_data;
  logic [3:0]  s_index;
  logic        s_last;

  logic [15:0] exp_q [$];

  fft_bitrev_buf #(.N(16)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_index (o_index),
    .o_last  (o_last),
    .i_ready (i_ready)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Driver: called at a falling edge; applies inputs, samples outputs 1ns
  // later, then waits through the rising edge to the next falling edge.
  task automatic drive_cycle(input logic v, input logic [15:0] d, input logic r);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    #1;
    s_ready = o_ready;
    s_valid = o_valid;
    s_data  = o_data;
    s_index = o_index;
    s_last  = o_last;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive_cycle(1'b0, 16'h0, 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b0);
    i_rst = 1'b0;
    drive_cycle(1'b0, 16'h0, 1'b0);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
    n_checks++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", s_last); end
    n_checks++; if (s_index !== 4'd0) begin n_fail++; $display("FAIL reset_index got=%0d exp=0", s_index); end
  endtask

  task automatic test_single_frame();
    logic [15:0] e;
    for (int w = 0; w < 16; w++) begin
      drive_cycle(1'b1, 16'(w), 1'b1);
      n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid w=%0d got=%b exp=0", w, s_valid); end
    end
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      e = 16'(brev[k]);
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid k=%0d got=%b exp=1", k, s_valid); end
      n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL single_data k=%0d got=%0d exp=%0d", k, s_data, e); end
      n_checks++; if (s_index !== 4'(k)) begin n_fail++; $display("FAIL single_index k=%0d got=%0d exp=%0d", k, s_index, k); end
      n_checks++; if (s_last !== (k == 15)) begin n_fail++; $display("FAIL single_last k=%0d got=%b", k, s_last); end
    end
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid got=%b exp=0", s_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int p;
    for (int c = 0; c < 64; c++) begin
      drive_cycle(c < 48, 16'(c), 1'b1);
      if (c < 48) begin
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, s_ready); end
      end
      if (c < 16) begin
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid c=%0d got=%b exp=0", c, s_valid); end
      end else begin
        p = c - 16;
        e = 16'((p / 16) * 16 + brev[p % 16]);
        n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, s_valid); end
        n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL b2b_data c=%0d got=%0d exp=%0d", c, s_data, e); end
        n_checks++; if (s_last !== ((p % 16) == 15)) begin n_fail++; $display("FAIL b2b_last c=%0d got=%b", c, s_last); end
      end
    end
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_valid got=%b exp=0", s_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    for (int i = 0; i < 32; i++) begin
      drive_cycle(1'b1, 16'(100 + i), 1'b0);
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready i=%0d got=%b exp=1", i, s_ready); end
    end
    for (int h = 0; h < 3; h++) begin
      drive_cycle(1'b1, 16'd999, 1'b0);
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready h=%0d got=%b exp=0", h, s_ready); end
    end
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      e = 16'(100 + brev[k]);
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_drain0_ready k=%0d got=%b exp=0", k, s_ready); end
      n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL bp_drain0_data k=%0d got=%0d exp=%0d", k, s_data, e); end
    end
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      e = 16'(116 + brev[k]);
      if (k == 0) begin
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got=%b exp=1", s_ready); end
      end
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain1_valid k=%0d got=%b exp=1", k, s_valid); end
      n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL bp_drain1_data k=%0d got=%0d exp=%0d", k, s_data, e); end
    end
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_accepted got=%b exp=0", s_valid); end
  endtask

  task automatic test_stall_toggle();
    logic [15:0] e;
    logic r;
    int k;
    int cyc;
    for (int w = 0; w < 16; w++) drive_cycle(1'b1, 16'(16'h40 + w), 1'b0);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 64) begin
      r = ((cyc % 2) == 0);
      drive_cycle(1'b0, 16'h0, r);
      e = 16'(16'h40 + brev[k]);
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, s_valid); end
      n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL stall_data cyc=%0d got=%0h exp=%0h", cyc, s_data, e); end
      n_checks++; if (s_index !== 4'(k)) begin n_fail++; $display("FAIL stall_index cyc=%0d got=%0d exp=%0d", cyc, s_index, k); end
      if (r) k++;
      cyc++;
    end
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL stall_timeout got=%0d exp=16", k); end
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after_valid got=%b exp=0", s_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] e;
    for (int w = 0; w < 16; w++) drive_cycle(1'b1, 16'(16'hB0 + w), 1'b0);
    for (int w = 0; w < 7; w++) drive_cycle(1'b1, 16'(16'hA0 + w), 1'b1);
    i_rst = 1'b1;
    drive_cycle(1'b0, 16'h0, 1'b1);
    i_rst = 1'b0;
    drive_cycle(1'b0, 16'h0, 1'b0);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", s_ready); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", s_valid); end
    n_checks++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last got=%b exp=0", s_last); end
    n_checks++; if (s_index !== 4'd0) begin n_fail++; $display("FAIL rstmid_index got=%0d exp=0", s_index); end
    for (int w = 0; w < 16; w++) begin
      drive_cycle(1'b1, 16'(w), 1'b0);
      n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_valid w=%0d got=%b exp=0", w, s_valid); end
    end
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1'b0, 16'h0, 1'b1);
      e = 16'(brev[k]);
      n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL rstmid_data k=%0d got=%0h exp=%0h", k, s_data, e); end
    end
    drive_cycle(1'b0, 16'h0, 1'b1);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_valid got=%b exp=0", s_valid); end
  endtask

  task automatic test_random();
    logic [15:0] frame [16];
    logic [15:0] e;
    logic [15:0] d;
    logic v;
    logic r;
    int written;
    int wk;
    int rk;
    int full_frames;
    int cyc;
    written = 0;
    wk = 0;
    rk = 0;
    full_frames = 0;
    cyc = 0;
    exp_q.delete();
    while ((written < 1200 || exp_q.size() != 0) && cyc < 20000) begin
      v = (written < 1200) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = 16'($urandom_range(0, 65535));
      drive_cycle(v, d, r);
      n_checks++; if (s_ready !== (full_frames < 2)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b frames=%0d", cyc, s_ready, full_frames); end
      n_checks++; if (s_valid !== (full_frames > 0)) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b frames=%0d", cyc, s_valid, full_frames); end
      if (s_valid === 1'b1 && r) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rand_extra cyc=%0d got=%0h exp=none", cyc, s_data);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (s_data !== e) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%0h exp=%0h", cyc, s_data, e); end
        end
        n_checks++; if (s_index !== 4'(rk)) begin n_fail++; $display("FAIL rand_index cyc=%0d got=%0d exp=%0d", cyc, s_index, rk); end
        n_checks++; if (s_last !== (rk == 15)) begin n_fail++; $display("FAIL rand_last cyc=%0d got=%b", cyc, s_last); end
        rk++;
        if (rk == 16) begin
          rk = 0;
          full_frames--;
        end
      end
      if (v && s_ready === 1'b1) begin
        frame[wk] = d;
        wk++;
        written++;
        if (wk == 16) begin
          for (int j = 0; j < 16; j++) exp_q.push_back(frame[brev[j]]);
          wk = 0;
          full_frames++;
        end
      end
      cyc++;
    end
    n_checks++; if (written != 1200 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout written=%0d pending=%0d exp=1200/0", written, exp_q.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_stall_toggle();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_buf.md
# fft_bitrev_buf

Bit-reversal reorder buffer that sits between the 16-point FFT datapath and downstream consumers. Accepts one N-bit sample per cycle in natural order, buffers full 16-sample frames in a ping-pong pair of register banks, and streams each frame out in bit-reversed address order with valid/ready handshakes on both sides. One bank fills while the other drains, so sustained throughput is one sample per cycle.

## Interface

Parameters:
- N, 16, sample width in bits (the same width the FFT adders carry)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  input sample present
- i_data  input  N  input sample, natural order
- o_ready  output  1  buffer can accept a sample this cycle
- o_valid  output  1  output sample present
- o_data  output  N  output sample, bit-reversed order
- o_index  output  4  output position within frame, 0..15
- o_last  output  1  high with the 16th output sample of a frame
- i_ready  input  1  downstream accepts the sample this cycle

## Operation

- State: bank_full[1:0], wr_bank, wr_cnt[3:0], rd_bank, rd_cnt[3:0], two 16xN banks.
- Reset: bank_full=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, so o_ready=1, o_valid=0, o_last=0, o_index=0. Bank contents are not reset. o_data is don't-care while o_valid=0.
- o_ready = !bank_full[wr_bank]. Write fires on i_valid && o_ready:
  - bank[wr_bank][wr_cnt] <= i_data, wr_cnt++.
  - On wr_cnt==15: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- o_valid = bank_full[rd_bank]. o_data = bank[rd_bank][bitrev4(rd_cnt)], combinational from registers. o_index = rd_cnt. o_last = o_valid && rd_cnt==15.
- Read fires on o_valid && i_ready:
  - rd_cnt++.
  - On rd_cnt==15: bank_full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- bitrev4(k) = {k[0],k[1],k[2],k[3]}.
- Simultaneous write and read always target different banks, because writing needs a bank that is not full and reading needs a bank that is full. No arbitration is needed.
- Both banks full: o_ready=0 until the reader finishes a bank. Input data is held by the upstream source.
- o_valid && !i_ready: o_data, o_index and o_last stay stable, and rd_cnt holds.
- Reset mid-frame: partial write and read frames are discarded. There is no partial-frame flush. Frames are always exactly 16 samples.
- Data passes through unmodified. No width change, no arithmetic.

## Timing

- Write-to-output latency: the 16th write of a frame is accepted in cycle t, and o_valid rises in cycle t+1 with the sample from natural index 0.
- Throughput: with i_valid=1 and i_ready=1 held continuously, o_ready never drops and o_valid stays high from cycle 16 on. One sample per cycle, no bubbles at bank swaps.
- i_ready has no combinational path to o_ready. o_ready depends only on registered state.

## Structure

- Shared package fft_pkg holds FFT_POINTS=16, FFT_LOG2=4 and a bitrev function parameterised on FFT_LOG2. These are reused by the twiddle ROM and the butterfly stages.
- Sub-module fft_reg_bank: a 16xN register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). Instantiate it twice.
- The top level holds the counters, the bank_full flags and the output multiplexing.

## Test plan

- Reset, then write 0..15 with i_ready=1. Required: o_valid first high one cycle after the last write. o_data sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. o_index 0..15. o_last only on the sample 15.
- Stream 48 samples 0..47 back-to-back with i_ready=1. Required: o_ready stays 1 throughout. Output is three contiguous bit-reversed frames; the second frame starts 16,24,20,28. No gap cycles.
- Write 32 samples with i_ready=0. Required: o_ready drops after the 32nd write, and a 33rd i_valid is not accepted. Raise i_ready: frame 0 drains, and o_ready returns 1 the cycle after o_last.
- Toggle i_ready 1,0,1,0 during a drain. Required: each held cycle keeps o_data and o_index stable, and no sample is duplicated or skipped.
- Assert i_rst after 7 writes, then write 0..15. Required: the first output frame is 0,8,4,..., and no pre-reset data appears. All outputs take their reset values one cycle after i_rst.
- Random i_valid/i_ready (≥1000 samples) against a scoreboard model. Required: bit-reversed order and no loss or duplication.
